dram_ctrl: RTL



---
 rtl/dram_pkg.sv | 15 +
 rtl/dram_if.sv | 25 ++
 rtl/dram_refresh_timer.sv | 56 +++++
 rtl/dram_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and constants for the dual-port DRAM request front-end.
package dram_pkg;

  typedef enum logic {
    StRun     = 1'b0,
    StRefresh = 1'b1
  } state_e;

  localparam int unsigned DefaultAddrW = 4;
  localparam int unsigned DefaultDataW = 16;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/dram_if.sv
// One client request/response stream: valid/ready request plus unbuffered read response.
interface dram_if import dram_pkg::*; #(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/dram_refresh_timer.sv
// Refresh scheduler: period counter flags the due cycle, burst counter times the REFRESH state.
module dram_refresh_timer import dram_pkg::*; #(
  parameter int unsigned REFRESH_PERIOD = 64,
  parameter int unsigned REFRESH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic refresh_due_o,
  output logic refresh_active_o
);

  localparam int unsigned PerW = $clog2(REFRESH_PERIOD);
  localparam int unsigned BurW = $clog2(REFRESH_CYCLES + 1);
  localparam logic [PerW-1:0] PerReload = PerW'(REFRESH_PERIOD - 1);
  localparam logic [BurW-1:0] BurLast   = BurW'(REFRESH_CYCLES - 1);

  state_e          state_d, state_q;
  logic [PerW-1:0] per_d, per_q;
  logic [BurW-1:0] bur_d, bur_q;

  assign refresh_due_o    = (state_q == StRun) && (per_q == '0);
  assign refresh_active_o = (state_q == StRefresh);

  // The period counter keeps running through REFRESH so refresh starts stay exactly periodic.
  always_comb begin
    state_d = state_q;
    per_d   = per_q - PerW'(1);
    bur_d   = bur_q;
    unique case (state_q)
      StRun: begin
        if (refresh_due_o) begin
          state_d = StRefresh;
          per_d   = PerReload;
          bur_d   = '0;
        end
      end
      StRefresh: begin
        if (bur_q == BurLast) state_d = StRun;
        else                  bur_d   = bur_q + BurW'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      per_q   <= PerReload;
      bur_q   <= '0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      bur_q   <= bur_d;
    end
  end

endmodule

// File: rtl/dram_ctrl.sv
// Dual-port DRAM front-end: refresh blocking, same-address round-robin arbitration,
// zero-latency command issue and one-cycle read response flags.
module dram_ctrl import dram_pkg::*; #(
  parameter int unsigned ADDR_W         = DefaultAddrW,
  parameter int unsigned DATA_W         = DefaultDataW,
  parameter int unsigned REFRESH_PERIOD = 64,
  parameter int unsigned REFRESH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  dram_if.slave             a,
  dram_if.slave             b,
  output logic              mem_we_a,
  output logic              mem_re_a,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [DATA_W-1:0] mem_wdata_a,
  input  logic [DATA_W-1:0] mem_rdata_a,
  output logic              mem_we_b,
  output logic              mem_re_b,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic [DATA_W-1:0] mem_wdata_b,
  input  logic [DATA_W-1:0] mem_rdata_b,
  output logic              mem_refresh,
  output logic              refresh_active
);

  logic due, in_refresh, blocked, conflict;
  logic ready_a, ready_b, gnt_a, gnt_b;
  logic ptr_d, ptr_q;
  logic rsp_valid_a_d, rsp_valid_a_q, rsp_valid_b_d, rsp_valid_b_q;

  dram_refresh_timer #(
    .REFRESH_PERIOD (REFRESH_PERIOD),
    .REFRESH_CYCLES (REFRESH_CYCLES)
  ) u_timer (
    .clk              (clk),
    .rst              (rst),
    .refresh_due_o    (due),
    .refresh_active_o (in_refresh)
  );

  assign blocked  = rst | due | in_refresh;
  // Read/read to one address is harmless; only a write makes same-address access a conflict.
  assign conflict = a.req_valid & b.req_valid & (a.req_addr == b.req_addr)
                  & (a.req_we | b.req_we);
  assign ready_a  = ~blocked & (~conflict | (ptr_q == PORT_A));
  assign ready_b  = ~blocked & (~conflict | (ptr_q == PORT_B));
  assign gnt_a    = a.req_valid & ready_a;
  assign gnt_b    = b.req_valid & ready_b;

  always_comb begin
    ptr_d = ptr_q;
    if (conflict && !blocked) ptr_d = (ptr_q == PORT_A) ? PORT_B : PORT_A;
    rsp_valid_a_d = gnt_a & ~a.req_we;
    rsp_valid_b_d = gnt_b & ~b.req_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= PORT_A;
      rsp_valid_a_q <= 1'b0;
      rsp_valid_b_q <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      rsp_valid_a_q <= rsp_valid_a_d;
      rsp_valid_b_q <= rsp_valid_b_d;
    end
  end

  assign a.req_ready = ready_a;
  assign b.req_ready = ready_b;
  // Gating with rst keeps a response from the cycle before reset from leaking out.
  assign a.rsp_valid = rsp_valid_a_q & ~rst;
  assign b.rsp_valid = rsp_valid_b_q & ~rst;
  assign a.rsp_rdata = mem_rdata_a;
  assign b.rsp_rdata = mem_rdata_b;

  assign mem_we_a    = gnt_a & a.req_we;
  assign mem_re_a    = gnt_a & ~a.req_we;
  assign mem_addr_a  = gnt_a ? a.req_addr : '0;
  assign mem_wdata_a = gnt_a ? a.req_wdata : '0;
  assign mem_we_b    = gnt_b & b.req_we;
  assign mem_re_b    = gnt_b & ~b.req_we;
  assign mem_addr_b  = gnt_b ? b.req_addr : '0;
  assign mem_wdata_b = gnt_b ? b.req_wdata : '0;

  assign mem_refresh    = in_refresh & ~rst;
  assign refresh_active = in_refresh & ~rst;

endmodule
